fetch_stage: RTL
================

// Module: fetch_stage
// PURPOSE
//   Pipelined instruction-fetch stage, upstream of decode/control in the pipelined core.
//   Owns the fetch PC and drives a synchronous instruction memory (1-cycle read latency).
//   Feeds an IF/ID register to decode, with stall, redirect (branch/jump) and flush
//   handling. A 1-entry skid buffer catches the in-flight fetch when decode stalls.
// PARAMETERS
//   DATA_WIDTH  32            instruction/PC width
//   RESET_PC    32'h0000_0000 first fetch address after reset
//   NOP_INSTR   32'h0000_0013 value of instr_d when not valid (addi x0,x0,0)
// PORTS
//   clk          in   1   clock, all state updates on rising edge
//   rst          in   1   synchronous reset, active-high
//   stall_d      in   1   decode cannot accept; hold IF/ID
//   redirect     in   1   taken branch/jump from execute; flush fetch
//   redirect_pc  in   32  target PC when redirect=1
//   imem_req     out  1   read request this cycle (comb)
//   imem_addr    out  32  read address = pc_f (comb)
//   imem_rdata   in   32  read data, valid the cycle after imem_req
//   valid_d      out  1   IF/ID holds a real instruction
//   instr_d      out  32  IF/ID instruction
//   pc_d         out  32  IF/ID PC
//   pc_plus4_d   out  32  IF/ID PC+4 (registered)
// BEHAVIOUR
//   Reset: pc_f=RESET_PC; req_q=0, skid_v=0, valid_d=0; instr_d=NOP_INSTR;
//     pc_d=0; pc_plus4_d=0. imem_req=0 while rst=1.
//   Issue: imem_req = !rst && !stall_d && !redirect. On issue: pc_f <= pc_f+4
//     (mod 2^32), req_q <= 1, req_pc_q <= pc_f; else req_q <= 0.
//   Response: when req_q=1, imem_rdata and req_pc_q form the returning instruction.
//   IF/ID load (stall_d=0): source = skid if skid_v, else response if req_q,
//     else bubble (valid_d<=0, instr_d<=NOP_INSTR). Skid is drained (skid_v<=0).
//   Stall (stall_d=1): IF/ID holds all fields. A response arriving (req_q=1)
//     is written to skid (skid_v<=1). The skid never overflows, because no
//     request issues while stalled.
//   Occupancy FSM: RUN (stall_d=0); HOLD (stalled, skid empty); SKID (stalled,
//     skid full). RUN->HOLD: stall_d=1 and req_q=0. RUN->SKID: stall_d=1 and
//     req_q=1. HOLD->SKID: never (no issue). HOLD/SKID->RUN: stall_d=0.
//     Any state->RUN on redirect.
//   Redirect: priority over stall and over load. At the edge: pc_f <= {redirect_pc[31:2],2'b00},
//     req_q<=0, skid_v<=0, valid_d<=0, instr_d<=NOP_INSTR. No request issues in the
//     redirect cycle. The target is fetched in the next cycle. Its instruction is valid_d
//     2 cycles after it issues.
//   Latency: issue at cycle n -> valid_d=1 with that instr from cycle n+2 (no stall).
//     After reset release at cycle 0: RESET_PC is issued at cycle 0, valid_d at cycle 2.
//   Throughput: 1 instr/cycle when unstalled. One bubble after a stall releases
//     from HOLD. No bubble from SKID.
//   Ordering: instructions reach IF/ID in strict program order. No duplicates, no drops.
//   rst mid-operation: all in-flight and skid contents are discarded. The
//     imem_rdata of the prior request is ignored.
// TESTING
//   Reset release, no stall -> imem_addr 0,4,8.. per cycle; valid_d=1 at cycle 2
//     with pc_d=0, then pc_d=4,8 on consecutive cycles; pc_plus4_d=pc_d+4.
//   stall_d=1 for 3 cycles while req in flight -> IF/ID frozen, skid captures the
//     next instr, imem_req=0. On release, the skid instr appears next with no gap or duplicate.
//   redirect=1, redirect_pc=0x100, with stall_d=1 and skid full -> next cycle
//     valid_d=0 and imem_addr=0x100; pc_d=0x100 two cycles later.
//   redirect_pc=0x103 -> fetch address 0x100.
//   Run with pc_f=0xFFFF_FFFC -> next imem_addr=0x0000_0000 (wrap).
//   rst=1 mid-stream with skid full -> next cycle valid_d=0, instr_d=0x13,
//     imem_addr=RESET_PC. The stale rdata never reaches IF/ID.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the fetch PC, drives a 1-cycle synchronous
// instruction memory and loads the IF/ID register with a 1-entry skid buffer.
module fetch_stage #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall_d,
  input  logic                  redirect,
  input  logic [DATA_WIDTH-1:0] redirect_pc,
  output logic                  imem_req,
  output logic [DATA_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  output logic                  valid_d,
  output logic [DATA_WIDTH-1:0] instr_d,
  output logic [DATA_WIDTH-1:0] pc_d,
  output logic [DATA_WIDTH-1:0] pc_plus4_d
);

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    HOLD = 2'd1,
    SKID = 2'd2
  } state_e;

  localparam logic [DATA_WIDTH-1:0] FOUR = DATA_WIDTH'(4);

  state_e                state_q;
  logic [DATA_WIDTH-1:0] pc_f_q;
  logic                  req_q;
  logic [DATA_WIDTH-1:0] req_pc_q;
  logic [DATA_WIDTH-1:0] skid_instr_q;
  logic [DATA_WIDTH-1:0] skid_pc_q;
  logic                  valid_q;
  logic [DATA_WIDTH-1:0] instr_q;
  logic [DATA_WIDTH-1:0] pc_q;
  logic [DATA_WIDTH-1:0] pc4_q;
  logic                  skid_v;
  logic                  issue;
  logic                  unused_lsb;

  // Targets are word-aligned; the low bits of redirect_pc are dropped.
  assign unused_lsb = ^redirect_pc[1:0];

  assign issue     = !rst && !stall_d && !redirect;
  assign imem_req  = issue;
  assign imem_addr = pc_f_q;
  assign skid_v    = (state_q == SKID);

  assign valid_d    = valid_q;
  assign instr_d    = instr_q;
  assign pc_d       = pc_q;
  assign pc_plus4_d = pc4_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= RUN;
      pc_f_q       <= RESET_PC;
      req_q        <= 1'b0;
      req_pc_q     <= '0;
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
      valid_q      <= 1'b0;
      instr_q      <= NOP_INSTR;
      pc_q         <= '0;
      pc4_q        <= '0;
    end else if (redirect) begin
      state_q <= RUN;
      pc_f_q  <= {redirect_pc[DATA_WIDTH-1:2], 2'b00};
      req_q   <= 1'b0;
      valid_q <= 1'b0;
      instr_q <= NOP_INSTR;
    end else begin
      req_q <= issue;
      if (issue) begin
        pc_f_q   <= pc_f_q + FOUR;
        req_pc_q <= pc_f_q;
      end
      if (!stall_d) begin
        state_q <= RUN;
        unique case (1'b1)
          skid_v: begin
            valid_q <= 1'b1;
            instr_q <= skid_instr_q;
            pc_q    <= skid_pc_q;
            pc4_q   <= skid_pc_q + FOUR;
          end
          req_q: begin
            valid_q <= 1'b1;
            instr_q <= imem_rdata;
            pc_q    <= req_pc_q;
            pc4_q   <= req_pc_q + FOUR;
          end
          default: begin
            valid_q <= 1'b0;
            instr_q <= NOP_INSTR;
          end
        endcase
      end else begin
        // Only RUN can have a response in flight; nothing issues once stalled.
        if (state_q == RUN) begin
          if (req_q) begin
            state_q      <= SKID;
            skid_instr_q <= imem_rdata;
            skid_pc_q    <= req_pc_q;
          end else begin
            state_q <= HOLD;
          end
        end
      end
    end
  end

endmodule
